// File: rtl/controller_pkg.sv
// Shared types and constants for the NES/SNES controller reader.
package controller_pkg;

  typedef enum logic [1:0] {
    CTRL_NES  = 2'b00,
    CTRL_SNES = 2'b01
  } ctrl_type_t;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT0,
    CLK_LOW,
    CLK_HIGH,
    DONE
  } state_t;

  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  // NES bit positions in buttons
  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  // SNES bit positions in buttons
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/controller_reader.sv
// Polls an NES/SNES controller over latch/clock/data and publishes the button vector.
// Build option: CTRL_SYNC_EN adds a 2-flop synchronizer on ctrl_data.
//
// state    | meaning
// IDLE     | waiting POLL_CYCLES between polls
// LATCH    | ctrl_latch high for 2T
// WAIT0    | gap after latch, bit 0 sampled at its end
// CLK_LOW  | ctrl_clk low for T
// CLK_HIGH | ctrl_clk high for T, bit k sampled at its end
// DONE     | publish buttons, pulse valid
module controller_reader
  import controller_pkg::*;
#(
  parameter int HALF_CYCLES = 300,
  parameter int POLL_CYCLES = 833_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sel,
  input  logic        ctrl_data,
  output logic        ctrl_latch,
  output logic        ctrl_clk,
  output logic [15:0] buttons,
  output logic        valid
);

  localparam int PW = $clog2(2 * HALF_CYCLES);
  localparam int CW = $clog2(POLL_CYCLES + 1);
  localparam logic [PW-1:0] T_LAST = PW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0] L_LAST = PW'(2 * HALF_CYCLES - 1);
  localparam logic [CW-1:0] P_LAST = CW'(POLL_CYCLES - 1);
  localparam logic [3:0]    NES_LAST  = 4'(NES_BITS - 1);
  localparam logic [3:0]    SNES_LAST = 4'(SNES_BITS - 1);

  state_t        state, state_nx;
  logic [PW-1:0] phase;
  logic [CW-1:0] poll_cnt;
  logic [3:0]    bit_cnt, bit_last;
  logic [15:0]   shift;
  logic          data_s;
  logic          sel_ok, phase_end;

`ifdef CTRL_SYNC_EN
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (ctrl_data),
    .q   (data_s)
  );
`else
  assign data_s = ctrl_data;
`endif

  assign sel_ok    = ~sel[1];
  assign phase_end = (state == LATCH) ? (phase == L_LAST) : (phase == T_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (sel_ok && !valid && poll_cnt == P_LAST) state_nx = LATCH;
      LATCH:    if (phase_end) state_nx = WAIT0;
      WAIT0:    if (phase_end) state_nx = CLK_LOW;
      CLK_LOW:  if (phase_end) state_nx = CLK_HIGH;
      CLK_HIGH: if (phase_end) state_nx = (bit_cnt == bit_last) ? DONE : CLK_LOW;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= '0;
      poll_cnt   <= '0;
      bit_cnt    <= '0;
      bit_last   <= '0;
      shift      <= '0;
      ctrl_latch <= 1'b0;
      ctrl_clk   <= 1'b1;
      buttons    <= '0;
      valid      <= 1'b0;
    end else begin
      ctrl_latch <= (state_nx == LATCH);
      ctrl_clk   <= (state_nx != CLK_LOW);
      valid      <= (state == DONE);
      phase      <= (state_nx == state && state != IDLE) ? phase + 1'b1 : '0;

      // The poll interval starts counting after the cycle that publishes buttons.
      if (state == IDLE) begin
        if (!sel_ok || valid || poll_cnt == P_LAST) poll_cnt <= '0;
        else                                        poll_cnt <= poll_cnt + 1'b1;
        if (!sel_ok) buttons <= '0;
      end

      if (state == IDLE && state_nx == LATCH)
        bit_last <= (ctrl_type_t'(sel) == CTRL_SNES) ? SNES_LAST : NES_LAST;

      if (state == WAIT0 && phase_end) begin
        shift[0] <= ~data_s;
        bit_cnt  <= 4'd1;
      end

      if (state == CLK_HIGH && phase_end) begin
        shift[bit_cnt] <= ~data_s;
        bit_cnt        <= bit_cnt + 1'b1;
      end

      if (state == DONE)
        buttons <= (bit_last == NES_LAST) ? {8'h00, shift[7:0]} : shift;
    end
  end

endmodule

// File: tb/tb_controller_reader.sv
// Bench for controller_reader: table-driven and random polls against a shift-register pad model.
module tb_controller_reader;

  localparam int T = 4;
  localparam int P = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        ctrl_data;
  logic        ctrl_latch, ctrl_clk, valid;
  logic [15:0] buttons;

  logic [15:0] pad = '0;
  logic [15:0] sr  = '1;

  int checks = 0;
  int errors = 0;

  controller_reader #(.HALF_CYCLES(T), .POLL_CYCLES(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .ctrl_data  (ctrl_data),
    .ctrl_latch (ctrl_latch),
    .ctrl_clk   (ctrl_clk),
    .buttons    (buttons),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  // Controller: parallel load on latch, shift toward data on ctrl_clk rise, active-low.
  always @(posedge ctrl_clk or posedge ctrl_latch) begin
    if (ctrl_latch) sr <= ~pad;
    else            sr <= {1'b1, sr[15:1]};
  end
  assign ctrl_data = sr[0];

  typedef struct {
    logic [1:0]  s;
    logic [15:0] p;
    logic [15:0] exp_btn;
    int          exp_lat;
    int          exp_pulses;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  function automatic logic [15:0] ref_btn(input logic [1:0] s, input logic [15:0] p);
    return (s == 2'b01) ? p : {8'h00, p[7:0]};
  endfunction

  function automatic int ref_lat(input logic [1:0] s);
    int n;
    n = (s == 2'b01) ? 16 : 8;
    return 3 * T + 2 * (n - 1) * T + 1;
  endfunction

  // Runs one poll from IDLE. With sw set, sel is changed to s2 during the first CLK_HIGH.
  task automatic txn(input logic [1:0] s, input logic [15:0] p, input bit sw,
                     input logic [1:0] s2, input string name);
    int lat, pulses, lw;
    logic prev_clk;
    bit seen;
    sel = s;
    pad = p;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ctrl_latch) begin seen = 1; break; end
    end
    if (!seen) begin timeout({name, " latch"}); return; end
    lat = 0; lw = 1; pulses = 0; prev_clk = ctrl_clk; seen = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      lat++;
      if (ctrl_latch) lw++;
      if (ctrl_clk && !prev_clk) begin
        pulses++;
        if (sw && pulses == 1) sel = s2;
      end
      prev_clk = ctrl_clk;
      if (valid) begin seen = 1; break; end
    end
    if (!seen) begin timeout({name, " valid"}); return; end
    chk({name, " latency"}, lat, ref_lat(s));
    chk({name, " pulses"}, pulses, (s == 2'b01) ? 15 : 7);
    chk({name, " latch_width"}, lw, 2 * T);
    chk({name, " buttons"}, buttons, ref_btn(s, p));
  endtask

  vec_t vecs[5];

  initial begin
    int c, vcount;
    bit seen;
    logic [1:0] rs;
    logic [15:0] rp;

    vecs[0] = '{2'b00, 16'h0081, 16'h0081, 69, 7};
    vecs[1] = '{2'b01, 16'h0901, 16'h0901, 133, 15};
    vecs[2] = '{2'b00, 16'hFFFF, 16'h00FF, 69, 7};
    vecs[3] = '{2'b01, 16'hF000, 16'hF000, 133, 15};
    vecs[4] = '{2'b00, 16'h0000, 16'h0000, 69, 7};

    reset = 1'b1;
    sel   = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst latch", ctrl_latch, 1'b0);
    chk("rst clk", ctrl_clk, 1'b1);
    chk("rst buttons", buttons, 16'h0);
    chk("rst valid", valid, 1'b0);

    reset = 1'b0;
    c = 0; seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      c++;
      if (ctrl_latch) begin seen = 1; break; end
    end
    if (!seen) timeout("first latch");
    else chk("first latch delay", c, 10);
    seen = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (valid) begin seen = 1; break; end
    end
    if (!seen) timeout("first valid");
    else chk("first buttons", buttons, 16'h0);

    for (int i = 0; i < 5; i++) begin
      txn(vecs[i].s, vecs[i].p, 0, vecs[i].s, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table", i), buttons, vecs[i].exp_btn);
      chk($sformatf("vec%0d model lat", i), ref_lat(vecs[i].s), vecs[i].exp_lat);
    end

    // sel switches to SNES mid-transaction; current poll must stay NES
    txn(2'b00, 16'hA5C3, 1, 2'b01, "switch nes");
    chk("switch upper zero", buttons[15:8], 8'h00);
    txn(2'b01, 16'hA5C3, 0, 2'b01, "switch next snes");

    // no controller selected
    sel = 2'b10;
    @(negedge clk);
    chk("none clears buttons", buttons, 16'h0);
    c = 0; vcount = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (ctrl_latch) c++;
      if (valid) vcount++;
    end
    chk("none latch count", c, 0);
    chk("none valid count", vcount, 0);
    chk("none buttons", buttons, 16'h0);

    txn(2'b00, 16'h0081, 0, 2'b00, "after none");

    // back-to-back valid spacing and width
    c = 0; seen = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      c++;
      if (c == 1) chk("valid width", valid, 1'b0);
      if (valid) begin seen = 1; break; end
    end
    if (!seen) timeout("back-to-back");
    else chk("valid spacing", c, P + 69 + 1);
    chk("back-to-back buttons", buttons, 16'h0081);

    for (int i = 0; i < 6; i++) begin
      rs = 2'($urandom_range(0, 1));
      rp = 16'($urandom);
      txn(rs, rp, 0, rs, $sformatf("rand%0d", i));
    end

    // asynchronous reset while ctrl_clk is low
    txn(2'b01, 16'h1234, 0, 2'b01, "pre-reset");
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ctrl_latch) begin seen = 1; break; end
    end
    if (!seen) timeout("reset latch");
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!ctrl_clk) begin seen = 1; break; end
    end
    if (!seen) timeout("reset clk_low");
    #2 reset = 1'b1;
    #1;
    chk("mid rst latch", ctrl_latch, 1'b0);
    chk("mid rst clk", ctrl_clk, 1'b1);
    chk("mid rst buttons", buttons, 16'h0);
    chk("mid rst valid", valid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c = 0; vcount = 0; seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      c++;
      if (valid) vcount++;
      if (ctrl_latch) begin seen = 1; break; end
    end
    if (!seen) timeout("post-reset latch");
    else chk("post-reset latch delay", c, 10);
    chk("post-reset no valid", vcount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
